// File: rtl/msu_pkg.sv
`default_nettype none
// ============================================================================
// msu_pkg : register offsets, status bit positions, data FSM states, ID string
// Revision: 1.0
// ============================================================================
package msu_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_DATA     = 3'd1;
  localparam logic [2:0] REG_SEEK0    = 3'd0;
  localparam logic [2:0] REG_SEEK3    = 3'd3;
  localparam logic [2:0] REG_TRACK_LO = 3'd4;
  localparam logic [2:0] REG_TRACK_HI = 3'd5;
  localparam logic [2:0] REG_VOLUME   = 3'd6;
  localparam logic [2:0] REG_CONTROL  = 3'd7;

  // Status register bit positions; [2:0] carry the revision
  localparam int ST_DATA_BUSY     = 7;
  localparam int ST_AUDIO_BUSY    = 6;
  localparam int ST_REPEAT        = 5;
  localparam int ST_PLAYING       = 4;
  localparam int ST_TRACK_MISSING = 3;

  typedef enum logic [1:0] {
    DS_IDLE   = 2'd0,
    DS_FLUSH  = 2'd1,
    DS_FILL   = 2'd2,
    DS_STREAM = 2'd3
  } data_state_e;

  localparam logic [47:0] MSU_ID = "S-MSU1";

  // Offsets 2..7 spell the chip ID, first character at offset 2
  function automatic logic [7:0] id_byte(input logic [2:0] off);
    logic [7:0] b;
    b = 8'h00;
    case (off)
      3'd2:    b = MSU_ID[47:40];
      3'd3:    b = MSU_ID[39:32];
      3'd4:    b = MSU_ID[31:24];
      3'd5:    b = MSU_ID[23:16];
      3'd6:    b = MSU_ID[15:8];
      3'd7:    b = MSU_ID[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msu_ctrl_if.sv
`default_nettype none
// ============================================================================
// msu_ctrl_if : SNES bus side and HPS service side of the MSU-1 controller
// Revision: 1.0
// ============================================================================
interface msu_ctrl_if;
  logic        ENABLE;
  logic        RD_N;
  logic        WR_N;
  logic [23:0] ADDR;
  logic [7:0]  DIN;
  logic [7:0]  DOUT;
  logic [31:0] seek_addr;
  logic        seek_req;
  logic        fifo_wr;
  logic [7:0]  fifo_din;
  logic        fifo_ready;
  logic [15:0] track_out;
  logic        track_req;
  logic        track_mounting;
  logic        track_missing;
  logic        audio_end;
  logic [7:0]  volume_out;
  logic        play_out;
  logic        repeat_out;
  logic        resume_out;

  modport slave (
    input  ENABLE, RD_N, WR_N, ADDR, DIN,
    input  fifo_wr, fifo_din, track_mounting, track_missing, audio_end,
    output DOUT, seek_addr, seek_req, fifo_ready, track_out, track_req,
    output volume_out, play_out, repeat_out, resume_out
  );

  modport master (
    output ENABLE, RD_N, WR_N, ADDR, DIN,
    output fifo_wr, fifo_din, track_mounting, track_missing, audio_end,
    input  DOUT, seek_addr, seek_req, fifo_ready, track_out, track_req,
    input  volume_out, play_out, repeat_out, resume_out
  );
endinterface
`default_nettype wire

// File: rtl/msu_fifo.sv
`default_nettype none
// ============================================================================
// msu_fifo : synchronous byte FIFO with flush and occupancy count
// Revision: 1.0
// ============================================================================
module msu_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [7:0]             din_i,
  input  logic                   pop_i,
  output logic [7:0]             dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // A flush wins over any access in the same cycle
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge CLK) begin
    if (!RST_N || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/msu_ctrl.sv
`default_nettype none
// ============================================================================
// msu_ctrl : MSU-1 register decode, data prefetch streaming and audio status
// Build option: MSU_AUDIO_RESUME_EN latches control bit2 into resume_out
// Revision: 1.0
// ============================================================================
module msu_ctrl #(
  parameter logic [15:0] BASE_ADDR  = 16'h2000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          PREFILL    = 4,
  parameter logic [2:0]  REVISION   = 3'd2
) (
  input  logic      CLK,
  input  logic      RST_N,
  msu_ctrl_if.slave bus
);
  import msu_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   addr_off;
  logic [2:0]    reg_off;
  logic          addr_hit;
  logic [7:0]    addr_hi_unused;
  logic          rd_act, wr_act;
  logic          rd_prev_q, wr_prev_q;
  logic          rd_stb, wr_stb;
  logic          seek_wr, data_rd;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] fifo_count;

  data_state_e   state_q, state_d;
  logic          data_busy, fifo_rdy;

  logic [7:0]    rd_data, status;
  logic [7:0]    dout_q;
  logic [31:0]   seek_addr_q;
  logic          seek_req_q;
  logic [15:0]   track_q;
  logic          track_req_q;
  logic [7:0]    volume_q;
  logic          audio_busy_q, missing_q, playing_q, repeat_q;

  // Subtracting the base handles windows that are not 8-byte aligned
  assign addr_off       = bus.ADDR[15:0] - BASE_ADDR;
  assign addr_hit       = (addr_off[15:3] == 13'd0);
  assign reg_off        = addr_off[2:0];
  assign addr_hi_unused = bus.ADDR[23:16];

  assign rd_act = bus.ENABLE & ~bus.RD_N;
  assign wr_act = bus.ENABLE & ~bus.WR_N;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_prev_q <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      rd_prev_q <= rd_act;
      wr_prev_q <= wr_act;
    end
  end

  // One action per bus access, however long the strobe is held
  assign rd_stb  = rd_act & ~rd_prev_q & addr_hit;
  assign wr_stb  = wr_act & ~wr_prev_q & addr_hit;
  assign seek_wr = wr_stb & (reg_off == REG_SEEK3);
  assign data_rd = rd_stb & (reg_off == REG_DATA);

  always_ff @(posedge CLK) begin
    if (!RST_N) state_q <= DS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    data_busy = 1'b0;
    fifo_rdy  = 1'b0;
    case (state_q)
      DS_IDLE: state_d = DS_IDLE;
      DS_FLUSH: begin
        data_busy = 1'b1;
        state_d   = DS_FILL;
      end
      DS_FILL: begin
        data_busy = 1'b1;
        fifo_rdy  = ~fifo_full;
        if (fifo_count >= CW'(PREFILL)) state_d = DS_STREAM;
      end
      DS_STREAM: begin
        fifo_rdy = ~fifo_full;
        state_d  = DS_STREAM;
      end
      default: state_d = DS_IDLE;
    endcase
    if (seek_wr) state_d = DS_FLUSH;
  end

  // A byte arriving with a seek write belongs to the old stream
  assign fifo_push = bus.fifo_wr & fifo_rdy & ~seek_wr;
  assign fifo_pop  = data_rd & ~fifo_empty & ~data_busy;

  msu_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .flush_i (seek_wr),
    .push_i  (fifo_push),
    .din_i   (bus.fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    status                   = 8'h00;
    status[ST_DATA_BUSY]     = data_busy;
    status[ST_AUDIO_BUSY]    = audio_busy_q;
    status[ST_REPEAT]        = repeat_q;
    status[ST_PLAYING]       = playing_q;
    status[ST_TRACK_MISSING] = missing_q;
    status[2:0]              = REVISION;
  end

  always_comb begin
    rd_data = 8'h00;
    case (reg_off)
      REG_STATUS: rd_data = status;
      REG_DATA:   rd_data = (fifo_empty | data_busy) ? 8'h00 : fifo_head;
      default:    rd_data = id_byte(reg_off);
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)      dout_q <= 8'h00;
    else if (rd_stb) dout_q <= rd_data;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      seek_addr_q <= 32'h0;
      seek_req_q  <= 1'b0;
    end else begin
      seek_req_q <= seek_wr;
      if (wr_stb && !reg_off[2])
        seek_addr_q[{reg_off[1:0], 3'b000} +: 8] <= bus.DIN;
    end
  end

  // Later statements override earlier ones, so a bus write wins
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      track_q      <= 16'h0;
      track_req_q  <= 1'b0;
      volume_q     <= 8'h00;
      audio_busy_q <= 1'b0;
      missing_q    <= 1'b0;
      playing_q    <= 1'b0;
      repeat_q     <= 1'b0;
    end else begin
      track_req_q <= 1'b0;
      if (bus.audio_end && !repeat_q) playing_q <= 1'b0;
      if (audio_busy_q && !track_req_q && !bus.track_mounting) begin
        audio_busy_q <= 1'b0;
        missing_q    <= bus.track_missing;
      end
      if (wr_stb) begin
        case (reg_off)
          REG_TRACK_LO: track_q[7:0] <= bus.DIN;
          REG_TRACK_HI: begin
            track_q[15:8] <= bus.DIN;
            track_req_q   <= 1'b1;
            audio_busy_q  <= 1'b1;
            missing_q     <= 1'b0;
            playing_q     <= 1'b0;
            repeat_q      <= 1'b0;
          end
          REG_VOLUME: volume_q <= bus.DIN;
          REG_CONTROL: begin
            if (!audio_busy_q && !missing_q) begin
              playing_q <= bus.DIN[0];
              repeat_q  <= bus.DIN[1];
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MSU_AUDIO_RESUME_EN
  logic resume_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      resume_q <= 1'b0;
    end else if (wr_stb) begin
      if (reg_off == REG_TRACK_HI)
        resume_q <= 1'b0;
      else if (reg_off == REG_CONTROL && !audio_busy_q && !missing_q)
        resume_q <= bus.DIN[2];
    end
  end

  assign bus.resume_out = resume_q;
`else
  assign bus.resume_out = 1'b0;
`endif

  assign bus.DOUT       = dout_q;
  assign bus.seek_addr  = seek_addr_q;
  assign bus.seek_req   = seek_req_q;
  assign bus.fifo_ready = fifo_rdy;
  assign bus.track_out  = track_q;
  assign bus.track_req  = track_req_q;
  assign bus.volume_out = volume_q;
  assign bus.play_out   = playing_q;
  assign bus.repeat_out = repeat_q;

endmodule
`default_nettype wire

// File: tb/tb_msu_ctrl.sv
`default_nettype none
// ============================================================================
// tb_msu_ctrl : scoreboard bench for msu_ctrl with a queue-based reference model
// Revision: 1.0
// ============================================================================
module tb_msu_ctrl;
  localparam logic [15:0] BASE    = 16'h2000;
  localparam int          DEPTH   = 16;
  localparam int          PREFILL = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  msu_ctrl_if bus ();

  msu_ctrl #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .PREFILL    (PREFILL),
    .REVISION   (3'd2)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_rd_q [$];
  logic [31:0] exp_seek_q [$];
  logic [15:0] exp_trk_q [$];

  // Reference model state: dmode 0 = no seek yet, 1 = filling, 2 = streaming
  logic [7:0]  m_fifo [$];
  int          m_dmode;
  bit          m_abusy, m_missing, m_play, m_rep, m_resume;
  logic [7:0]  m_vol, m_dout;
  logic [31:0] m_seek;
  logic [15:0] m_track;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    m_dmode = 0; m_abusy = 0; m_missing = 0; m_play = 0; m_rep = 0; m_resume = 0;
    m_vol = 8'h00; m_dout = 8'h00; m_seek = 32'h0; m_track = 16'h0;
  endtask

  task automatic model_read(input logic [15:0] a, output logic [7:0] r);
    logic [15:0] off;
    off = a - BASE;
    if (off >= 16'd8) begin
      r = m_dout;
    end else begin
      case (off[2:0])
        3'd0: r = {(m_dmode == 1), m_abusy, m_rep, m_play, m_missing, 3'd2};
        3'd1: r = (m_dmode == 2 && m_fifo.size() > 0) ? m_fifo.pop_front() : 8'h00;
        3'd2: r = "S";
        3'd3: r = "-";
        3'd4: r = "M";
        3'd5: r = "S";
        3'd6: r = "U";
        default: r = "1";
      endcase
      m_dout = r;
    end
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    logic [15:0] off;
    off = a - BASE;
    if (off < 16'd8) begin
      case (off[2:0])
        3'd0: m_seek[7:0]   = d;
        3'd1: m_seek[15:8]  = d;
        3'd2: m_seek[23:16] = d;
        3'd3: begin
          m_seek[31:24] = d;
          m_fifo.delete();
          m_dmode = 1;
          exp_seek_q.push_back(m_seek);
        end
        3'd4: m_track[7:0] = d;
        3'd5: begin
          m_track[15:8] = d;
          m_abusy = 1; m_missing = 0; m_play = 0; m_rep = 0; m_resume = 0;
          exp_trk_q.push_back(m_track);
        end
        3'd6: m_vol = d;
        default: if (!m_abusy && !m_missing) begin
          m_play = d[0];
          m_rep  = d[1];
`ifdef MSU_AUDIO_RESUME_EN
          m_resume = d[2];
`endif
        end
      endcase
    end
  endtask

  task automatic model_push(input logic [7:0] d);
    if (m_dmode != 0 && m_fifo.size() < DEPTH) m_fifo.push_back(d);
    if (m_dmode == 1 && m_fifo.size() >= PREFILL) m_dmode = 2;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input int hold, input bit push_too);
    @(posedge CLK); #1;
    bus.ADDR = {8'($urandom), a}; bus.DIN = d; bus.ENABLE = 1'b1; bus.WR_N = 1'b0;
    if (push_too) begin bus.fifo_wr = 1'b1; bus.fifo_din = 8'($urandom); end
    model_write(a, d);
    @(posedge CLK); #1;
    bus.fifo_wr = 1'b0;
    for (int i = 1; i < hold; i++) begin @(posedge CLK); #1; end
    bus.WR_N = 1'b1; bus.ENABLE = 1'b0;
    idle(3);
  endtask

  task automatic bus_read(input logic [15:0] a, input int hold, input bit push_too);
    logic [7:0] e;
    logic [7:0] pd;
    @(posedge CLK); #1;
    model_read(a, e);
    exp_rd_q.push_back(e);
    bus.ADDR = {8'($urandom), a}; bus.ENABLE = 1'b1; bus.RD_N = 1'b0;
    if (push_too) begin
      pd = 8'($urandom);
      bus.fifo_wr = 1'b1; bus.fifo_din = pd;
      model_push(pd);
    end
    @(posedge CLK); #1;
    bus.fifo_wr = 1'b0;
    for (int i = 1; i < hold; i++) begin @(posedge CLK); #1; end
    bus.RD_N = 1'b1; bus.ENABLE = 1'b0;
    idle(3);
  endtask

  task automatic hps_push(input logic [7:0] d);
    @(posedge CLK); #1;
    bus.fifo_wr = 1'b1; bus.fifo_din = d;
    model_push(d);
    @(posedge CLK); #1;
    bus.fifo_wr = 1'b0;
  endtask

  task automatic seek(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      bus_write(BASE + 16'(i), a[8*i +: 8], $urandom_range(1, 3), 1'b0);
  endtask

  task automatic mount_done(input bit missing);
    @(posedge CLK); #1;
    bus.track_missing = missing; bus.track_mounting = 1'b0;
    m_abusy = 0; m_missing = missing;
    idle(3);
  endtask

  task automatic pulse_audio_end();
    @(posedge CLK); #1;
    bus.audio_end = 1'b1;
    if (!m_rep) m_play = 0;
    @(posedge CLK); #1;
    bus.audio_end = 1'b0;
    idle(2);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST_N = 1'b0;
    model_reset();
    idle(2); #1;
    RST_N = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_volume"}, {24'h0, bus.volume_out}, {24'h0, m_vol});
    chk({tag, "_play"}, {31'h0, bus.play_out}, {31'h0, m_play});
    chk({tag, "_repeat"}, {31'h0, bus.repeat_out}, {31'h0, m_rep});
    chk({tag, "_resume"}, {31'h0, bus.resume_out}, {31'h0, m_resume});
  endtask

  // Monitor: one DOUT comparison per strobe edge, one per request pulse
  bit mon_prev_rd = 0, mon_pending = 0, mon_prev_seek = 0, mon_prev_trk = 0;
  always @(negedge CLK) begin
    if (mon_pending) begin
      mon_pending = 0;
      if (exp_rd_q.size() == 0) chk("dout_unexpected", 32'h1, 32'h0);
      else chk("dout", {24'h0, bus.DOUT}, {24'h0, exp_rd_q.pop_front()});
    end
    if (RST_N && bus.ENABLE && !bus.RD_N && !mon_prev_rd) mon_pending = 1;
    mon_prev_rd = bus.ENABLE & ~bus.RD_N;
    if (bus.seek_req) begin
      if (mon_prev_seek || exp_seek_q.size() == 0) chk("seek_req_extra", 32'h1, 32'h0);
      else chk("seek_addr", bus.seek_addr, exp_seek_q.pop_front());
    end
    mon_prev_seek = bus.seek_req;
    if (bus.track_req) begin
      if (mon_prev_trk || exp_trk_q.size() == 0) chk("track_req_extra", 32'h1, 32'h0);
      else chk("track_out", {16'h0, bus.track_out}, {16'h0, exp_trk_q.pop_front()});
    end
    mon_prev_trk = bus.track_req;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    bus.ENABLE = 0; bus.RD_N = 1; bus.WR_N = 1; bus.ADDR = '0; bus.DIN = '0;
    bus.fifo_wr = 0; bus.fifo_din = '0; bus.track_mounting = 0;
    bus.track_missing = 0; bus.audio_end = 0;
    model_reset();
    idle(3); #1;
    RST_N = 1'b1;

    chk("rst_dout", {24'h0, bus.DOUT}, 32'h0);
    chk("rst_seek_addr", bus.seek_addr, 32'h0);
    chk("rst_track", {16'h0, bus.track_out}, 32'h0);
    chk("rst_fifo_ready", {31'h0, bus.fifo_ready}, 32'h0);
    check_outputs("rst");

    for (int i = 0; i < 8; i++) bus_read(BASE + 16'(i == 1 ? 0 : i), 1, 1'b0);

    // Basic stream
    seek(32'h0000_1234);
    bus_read(BASE, 1, 1'b0);
    for (int i = 0; i < 4; i++) hps_push(8'hA0 + 8'(i));
    idle(3);
    bus_read(BASE, 1, 1'b0);
    for (int i = 0; i < 5; i++) bus_read(BASE + 16'd1, 1, 1'b0);

    // Held strobe pops once
    for (int i = 0; i < 3; i++) hps_push(8'hB0 + 8'(i));
    idle(3);
    bus_read(BASE + 16'd1, 10, 1'b0);
    bus_read(BASE + 16'd1, 1, 1'b0);

    // Missing track blocks control writes
    bus.track_mounting = 1'b1;
    bus_write(BASE + 16'd4, 8'h05, 1, 1'b0);
    bus_write(BASE + 16'd5, 8'h00, 2, 1'b0);
    bus_read(BASE, 1, 1'b0);
    idle(20);
    mount_done(1'b1);
    bus_read(BASE, 1, 1'b0);
    bus_write(BASE + 16'd7, 8'h07, 1, 1'b0);
    check_outputs("missing");

    // Valid track: repeat survives audio_end, plain play does not
    bus.track_missing = 1'b0; bus.track_mounting = 1'b1;
    bus_write(BASE + 16'd4, 8'h06, 1, 1'b0);
    bus_write(BASE + 16'd5, 8'h00, 1, 1'b0);
    idle(10);
    mount_done(1'b0);
    bus_write(BASE + 16'd7, 8'h03, 1, 1'b0);
    pulse_audio_end();
    check_outputs("repeat_end");
    bus_write(BASE + 16'd7, 8'h05, 1, 1'b0);
    pulse_audio_end();
    check_outputs("play_end");
    bus_read(BASE, 1, 1'b0);

    // Volume, then writes/reads just outside the window
    bus_write(BASE + 16'd6, 8'h7F, 1, 1'b0);
    bus_write(BASE + 16'd14, 8'h11, 1, 1'b0);
    bus_write(BASE - 16'd1, 8'h22, 1, 1'b0);
    bus_read(BASE + 16'd8, 1, 1'b0);
    bus_read(BASE - 16'd2, 1, 1'b0);
    check_outputs("window");

    // Reseek during fill with a coincident HPS byte
    seek(32'hDEAD_BEEF);
    hps_push(8'h11); hps_push(8'h22);
    idle(2);
    bus_write(BASE + 16'd3, 8'h5A, 1, 1'b1);
    bus_read(BASE, 1, 1'b0);
    bus_read(BASE + 16'd1, 1, 1'b0);

    // Overfill, then drain past empty
    for (int i = 0; i < DEPTH + 3; i++) hps_push(8'($urandom));
    idle(3);
    chk("full_fifo_ready", {31'h0, bus.fifo_ready}, 32'h0);
    bus_read(BASE, 1, 1'b0);
    begin
      int n;
      n = m_fifo.size();
      for (int i = 0; i <= n; i++) bus_read(BASE + 16'd1, 1, 1'b0);
    end
    chk("drained_fifo_ready", {31'h0, bus.fifo_ready}, 32'h1);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 9))
        0: repeat ($urandom_range(1, 5)) hps_push(8'($urandom));
        1: bus_read(BASE + 16'd1, $urandom_range(1, 4), 1'b0);
        2: bus_read(BASE, $urandom_range(1, 3), 1'b0);
        3: bus_read(BASE + 16'($urandom_range(2, 7)), 1, 1'b0);
        4: bus_write(BASE + 16'd6, 8'($urandom), $urandom_range(1, 3), 1'b0);
        5: if ($urandom_range(0, 2) == 0) seek($urandom);
        6: if (m_fifo.size() < DEPTH) bus_read(BASE + 16'd1, 1, 1'b1);
        7: if ($urandom_range(0, 1) == 1)
             bus_read(BASE + 16'($urandom_range(8, 40)), 1, 1'b0);
           else
             bus_write(BASE + 16'($urandom_range(8, 40)), 8'($urandom), 1, 1'b0);
        8: begin
          bus_write(BASE + 16'd7, 8'($urandom), 1, 1'b0);
          check_outputs("rnd_ctrl");
        end
        default: begin
          pulse_audio_end();
          check_outputs("rnd_end");
        end
      endcase
    end

    // Reset while streaming with data queued
    repeat (5) hps_push(8'($urandom));
    do_reset();
    idle(2);
    chk("rst2_dout", {24'h0, bus.DOUT}, 32'h0);
    chk("rst2_fifo_ready", {31'h0, bus.fifo_ready}, 32'h0);
    chk("rst2_seek_addr", bus.seek_addr, 32'h0);
    check_outputs("rst2");
    bus_read(BASE, 1, 1'b0);
    bus_read(BASE + 16'd1, 1, 1'b0);

    idle(5);
    chk("left_reads", exp_rd_q.size(), 32'h0);
    chk("left_seeks", exp_seek_q.size(), 32'h0);
    chk("left_tracks", exp_trk_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
